// File: rtl/divider.sv
// Signed fixed-point divider, restoring shift-subtract, one quotient bit per cycle.
// out = sat(trunc(in1 * 2^(BITSIZE-2) / in2)), fixed latency.
module divider #(
  parameter int BITSIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [BITSIZE-1:0] in1,
  input  logic signed [BITSIZE-1:0] in2,
  output logic signed [BITSIZE-1:0] out,
  output logic                      busy,
  output logic                      done,
  output logic                      div_by_zero
);

  localparam int NW = 2*BITSIZE-2;
  localparam int CW = $clog2(NW+1);

  localparam logic [NW-1:0] QMAX =
    {{(NW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic [NW-1:0] QNEG =
    {{(NW-BITSIZE){1'b0}}, 1'b1, {(BITSIZE-1){1'b0}}};
  localparam logic signed [BITSIZE-1:0] SMAX =
    {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic signed [BITSIZE-1:0] SMIN =
    {1'b1, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SAT
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NW-1:0]      num_q, num_d;
  logic [NW-1:0]      quo_q, quo_d;
  logic [BITSIZE-1:0] rem_q, rem_d;
  logic [BITSIZE-1:0] den_q, den_d;
  logic               neg_q, neg_d;
  logic               aneg_q, aneg_d;
  logic               zero_q, zero_d;
  logic signed [BITSIZE-1:0] out_q, out_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [BITSIZE-1:0] mag1, mag2;
  logic [BITSIZE:0]   rem_sh;
  logic [BITSIZE-1:0] rem_sub;
  logic               ge;

  // Unsigned magnitudes; the most negative value maps to 2^(BITSIZE-1) exactly.
  assign mag1 = in1[BITSIZE-1] ? BITSIZE'(-in1) : BITSIZE'(in1);
  assign mag2 = in2[BITSIZE-1] ? BITSIZE'(-in2) : BITSIZE'(in2);

  assign out         = out_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      aneg_q  <= aneg_d;
      zero_q  <= zero_d;
      out_q   <= out_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state: accept, iterate one restoring step per cycle, then saturate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    zero_d  = zero_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, num_q[NW-1]};
    rem_sub = rem_sh[BITSIZE-1:0] - den_q;
    ge      = (rem_sh >= {1'b0, den_q});

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIV;
          cnt_d   = CW'(NW);
          num_d   = {mag1, {(BITSIZE-2){1'b0}}};
          quo_d   = '0;
          rem_d   = '0;
          den_d   = mag2;
          neg_d   = in1[BITSIZE-1] ^ in2[BITSIZE-1];
          aneg_d  = in1[BITSIZE-1];
          zero_d  = (in2 == '0);
        end
      end
      DIV: begin
        num_d = num_q << 1;
        quo_d = {quo_q[NW-2:0], ge};
        rem_d = ge ? rem_sub : rem_sh[BITSIZE-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = SAT;
        end
      end
      SAT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        if (zero_q) begin
          out_d = aneg_q ? SMIN : SMAX;
        end else if (!neg_q) begin
          out_d = (quo_q > QMAX) ? SMAX
                                 : $signed(quo_q[BITSIZE-1:0]);
        end else begin
          out_d = (quo_q > QNEG) ? SMIN
                                 : $signed(-quo_q[BITSIZE-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider.sv
// Testbench for divider (BITSIZE=16): vector table, handshake and
// reset sequences, and random operands against an arithmetic model.
module tb_divider;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [15:0] in1;
  logic signed [15:0] in2;
  logic signed [15:0] out;
  logic               busy;
  logic               done;
  logic               div_by_zero;

  int nvec;
  int nmis;
  int lat;
  int ndone;

  divider #(.BITSIZE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in1         (in1),
    .in2         (in2),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    a;
    int    b;
    int    q;
    bit    dbz;
    string nm;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  function automatic int model(input int a, input int b);
    longint n;
    if (b == 0) return (a < 0) ? -32768 : 32767;
    n = (longint'(a) * 16384) / longint'(b);
    if (n > 32767)  return 32767;
    if (n < -32768) return -32768;
    return int'(n);
  endfunction

  // One complete division starting from IDLE, with latency check.
  task automatic do_div(input int a, input int b, input int eq,
                        input bit edbz, input string nm);
    int l;
    l = 0;
    in1 = 16'(a);
    in2 = 16'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        l = k;
        break;
      end
    end
    chk({nm, "_lat"}, l, 31);
    chk({nm, "_out"}, out, eq);
    chk({nm, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    chk({nm, "_busy"}, 32'(busy), 0);
    tick();
    chk({nm, "_pulse"}, 32'(done), 0);
  endtask

  vec_t vt[$];

  initial begin
    nvec  = 0;
    nmis  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;

    vt.push_back('{8192,   16384, 8192,   1'b0, "basic"});
    vt.push_back('{4096,   8192,  8192,   1'b0, "half"});
    vt.push_back('{-8192,  16384, -8192,  1'b0, "neg"});
    vt.push_back('{1,      3,     5461,   1'b0, "trunc_p"});
    vt.push_back('{-1,     3,     -5461,  1'b0, "trunc_n"});
    vt.push_back('{-32768, -32768, 16384, 1'b0, "minmin"});
    vt.push_back('{16384,  4096,  32767,  1'b0, "sat_p"});
    vt.push_back('{-16384, 4096,  -32768, 1'b0, "sat_n"});
    vt.push_back('{100,    0,     32767,  1'b1, "dz_p"});
    vt.push_back('{-5,     0,     -32768, 1'b1, "dz_n"});
    vt.push_back('{0,      0,     32767,  1'b1, "dz_0"});
    vt.push_back('{-32768, 1,     -32768, 1'b0, "min_1"});

    repeat (2) tick();
    chk("rst_out", out, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    #2 rst_n = 1'b1;
    tick();

    foreach (vt[i])
      do_div(vt[i].a, vt[i].b, vt[i].q, vt[i].dbz, vt[i].nm);

    // start while busy with other operands, inputs moving after E0
    in1 = 16'sd8192;
    in2 = 16'sd16384;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5);
      in1 = 16'($urandom);
      in2 = (k == 5) ? 16'sd0 : 16'($urandom);
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("ign_lat", lat, 31);
    chk("ign_out", out, 8192);
    chk("ign_dbz", 32'(div_by_zero), 0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("ign_nodone", ndone, 0);
    chk("ign_hold", out, 8192);

    // start held across done: back-to-back accept
    in1 = 16'sd4096;
    in2 = 16'sd8192;
    start = 1'b1;
    tick();
    in1 = -16'sd8192;
    in2 = 16'sd16384;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("b2b_lat1", lat, 31);
    chk("b2b_out1", out, 8192);
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 15) chk("b2b_hold", out, 8192);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("b2b_lat2", lat, 31);
    chk("b2b_out2", out, -8192);
    tick();

    // reset in the middle of a division
    in1 = 16'sd16384;
    in2 = 16'sd4096;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_out", out, 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_dbz", 32'(div_by_zero), 0);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("mrst_nodone", ndone, 0);
    do_div(-1, 3, -5461, 1'b0, "mrst_fresh");

    // random operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      int a;
      int b;
      int m;
      m = int'($urandom_range(0, 3));
      a = int'($signed(16'($urandom)));
      b = int'($signed(16'($urandom)));
      if (m == 1) a = int'($urandom_range(0, 2000)) - 1000;
      if (m == 2) b = int'($urandom_range(0, 6)) - 3;
      if (m == 3 && i % 8 == 0) b = 0;
      do_div(a, b, model(a, b), b == 0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
